itch_add_order_decoder: RTL and testbench

Consumes the UDP payload byte stream produced by the Ethernet/IP/UDP parser stage and decodes MoldUDP64 packets into NASDAQ ITCH 5.0 Add Order ('A') messages for the order book. It walks the 20-byte MoldUDP64 header, then each length-prefixed message. It emits one registered, parallel add-order record per valid 'A' message and skips all other message types. Truncated packets are flagged.

---
 rtl/itch_add_order_decoder.sv | 172 +++++++++++++++++
 tb/tb_itch_add_order_decoder.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/itch_add_order_decoder.sv
// rtl/itch_add_order_decoder.sv - MoldUDP64 walker emitting ITCH 5.0 add-order records
// Define ITCH_SEQ_CHECK_EN to enable the header sequence-gap detector (seqGap).
module itch_add_order_decoder #(
   parameter logic [7:0] ADD_TYPE = 8'h41,
   parameter int         ADD_LEN  = 36
) (
   input  logic        clk,
   input  logic        rstN,
   input  logic        dataValid,
   input  logic [7:0]  data,
   output logic        orderValid,
   output logic [63:0] seqNum,
   output logic [15:0] locate,
   output logic [47:0] timeStamp,
   output logic [63:0] refNum,
   output logic        isBuy,
   output logic [31:0] shares,
   output logic [63:0] stock,
   output logic [31:0] price,
   output logic        pktErr,
   output logic        seqGap
);
   localparam logic [15:0] ADD_LEN16 = 16'(ADD_LEN);
   localparam logic [15:0] LAST_ADD  = 16'(ADD_LEN - 1);

   typedef enum logic [2:0] {HDR, LEN, BODY, SKIP, DONE} state_t;

   state_t        state;
   state_t        after_msg;
   logic [15:0]   byte_cnt;
   logic [15:0]   msg_len;
   logic [15:0]   msg_cnt;
   logic [15:0]   msg_idx;
   logic [63:0]   seq_base;
   logic [279:0]  rec;
   logic [287:0]  rec_nxt;
   logic [15:0]   cnt_full;
   logic [15:0]   len_full;
   logic [15:0]   idx_nxt;
   logic          unused_bits;

   // rec_nxt holds the full 36-byte message on its last byte, type byte in [287:280]
   assign rec_nxt     = {rec, data};
   assign cnt_full    = {msg_cnt[7:0], data};
   assign len_full    = {msg_len[7:0], data};
   assign idx_nxt     = msg_idx + 16'd1;
   assign after_msg   = (idx_nxt == msg_cnt) ? DONE : LEN;
   assign unused_bits = ^{rec_nxt[287:280], rec_nxt[263:248]};

`ifdef ITCH_SEQ_CHECK_EN
   logic [63:0] exp_seq;
`else
   assign seqGap = 1'b0;
`endif

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state      <= HDR;
         byte_cnt   <= 16'd0;
         msg_len    <= 16'd0;
         msg_cnt    <= 16'd0;
         msg_idx    <= 16'd0;
         seq_base   <= 64'd0;
         rec        <= '0;
         orderValid <= 1'b0;
         seqNum     <= 64'd0;
         locate     <= 16'd0;
         timeStamp  <= 48'd0;
         refNum     <= 64'd0;
         isBuy      <= 1'b0;
         shares     <= 32'd0;
         stock      <= 64'd0;
         price      <= 32'd0;
         pktErr     <= 1'b0;
`ifdef ITCH_SEQ_CHECK_EN
         seqGap     <= 1'b0;
         exp_seq    <= 64'd0;
`endif
      end else begin
         orderValid <= 1'b0;
         pktErr     <= 1'b0;
`ifdef ITCH_SEQ_CHECK_EN
         seqGap     <= 1'b0;
`endif
         if (!dataValid) begin
            // a packet that ends anywhere but between packets is truncated
            case (state)
               HDR:     if (byte_cnt != 16'd0) pktErr <= 1'b1;
               DONE:    ;
               default: pktErr <= 1'b1;
            endcase
            state    <= HDR;
            byte_cnt <= 16'd0;
         end else begin
            case (state)
               HDR: begin
                  if (byte_cnt >= 16'd10 && byte_cnt <= 16'd17)
                     seq_base <= {seq_base[55:0], data};
                  if (byte_cnt == 16'd18)
                     msg_cnt <= cnt_full;
                  if (byte_cnt == 16'd19) begin
                     msg_cnt  <= cnt_full;
                     msg_idx  <= 16'd0;
                     byte_cnt <= 16'd0;
                     state    <= (cnt_full == 16'd0 || cnt_full == 16'hFFFF) ? DONE : LEN;
`ifdef ITCH_SEQ_CHECK_EN
                     if (exp_seq != 64'd0 && exp_seq != seq_base)
                        seqGap <= 1'b1;
                     if (cnt_full != 16'd0 && cnt_full != 16'hFFFF)
                        exp_seq <= seq_base + {48'd0, cnt_full};
`endif
                  end else begin
                     byte_cnt <= byte_cnt + 16'd1;
                  end
               end
               LEN: begin
                  msg_len <= len_full;
                  if (byte_cnt == 16'd0) begin
                     byte_cnt <= 16'd1;
                  end else begin
                     byte_cnt <= 16'd0;
                     if (len_full == 16'd0) begin
                        msg_idx <= idx_nxt;
                        state   <= after_msg;
                     end else begin
                        state   <= BODY;
                     end
                  end
               end
               BODY: begin
                  byte_cnt <= byte_cnt + 16'd1;
                  if (byte_cnt == 16'd0 && !(data == ADD_TYPE && msg_len == ADD_LEN16)) begin
                     if (msg_len == 16'd1) begin
                        msg_idx  <= idx_nxt;
                        state    <= after_msg;
                        byte_cnt <= 16'd0;
                     end else begin
                        state    <= SKIP;
                     end
                  end else begin
                     rec <= rec_nxt[279:0];
                     if (byte_cnt == LAST_ADD) begin
                        orderValid <= 1'b1;
                        seqNum     <= seq_base + {48'd0, msg_idx};
                        locate     <= rec_nxt[279:264];
                        timeStamp  <= rec_nxt[247:200];
                        refNum     <= rec_nxt[199:136];
                        isBuy      <= (rec_nxt[135:128] == 8'h42);
                        shares     <= rec_nxt[127:96];
                        stock      <= rec_nxt[95:32];
                        price      <= rec_nxt[31:0];
                        msg_idx    <= idx_nxt;
                        state      <= after_msg;
                        byte_cnt   <= 16'd0;
                     end
                  end
               end
               SKIP: begin
                  if (byte_cnt == msg_len - 16'd1) begin
                     msg_idx  <= idx_nxt;
                     state    <= after_msg;
                     byte_cnt <= 16'd0;
                  end else begin
                     byte_cnt <= byte_cnt + 16'd1;
                  end
               end
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_itch_add_order_decoder.sv
// tb/tb_itch_add_order_decoder.sv - randomized packet bench with message-level reference model
module tb_itch_add_order_decoder;
   logic        clk = 1'b0;
   logic        rstN;
   logic        dataValid;
   logic [7:0]  data;
   logic        orderValid;
   logic [63:0] seqNum;
   logic [15:0] locate;
   logic [47:0] timeStamp;
   logic [63:0] refNum;
   logic        isBuy;
   logic [31:0] shares;
   logic [63:0] stock;
   logic [31:0] price;
   logic        pktErr;
   logic        seqGap;

   itch_add_order_decoder dut (
      .clk(clk), .rstN(rstN), .dataValid(dataValid), .data(data),
      .orderValid(orderValid), .seqNum(seqNum), .locate(locate),
      .timeStamp(timeStamp), .refNum(refNum), .isBuy(isBuy),
      .shares(shares), .stock(stock), .price(price),
      .pktErr(pktErr), .seqGap(seqGap)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [63:0] seq;
      logic [15:0] loc;
      logic [47:0] ts;
      logic [63:0] ref_num;
      logic        buy;
      logic [31:0] sh;
      logic [63:0] stk;
      logic [31:0] pr;
   } rec_t;

   int   n_chk = 0;
   int   n_pass = 0;
   int   err_cnt = 0;
   int   exp_err = 0;
   int   gap_cnt = 0;
   int   pkt_core;
   logic [7:0] pkt[$];
   rec_t pend_q[$];
   int   pend_end[$];
   rec_t exp_q[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // scoreboard: every orderValid must match the oldest expected record
   always @(negedge clk) begin
      if (rstN) begin
         if (pktErr) err_cnt++;
         if (seqGap) gap_cnt++;
         if (orderValid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_order", 64'd1, 64'd0);
            end else begin
               rec_t e;
               e = exp_q.pop_front();
               check("seq_num", seqNum, e.seq);
               check("locate", {48'd0, locate}, {48'd0, e.loc});
               check("timestamp", {16'd0, timeStamp}, {16'd0, e.ts});
               check("ref_num", refNum, e.ref_num);
               check("is_buy", {63'd0, isBuy}, {63'd0, e.buy});
               check("shares", {32'd0, shares}, {32'd0, e.sh});
               check("stock", stock, e.stk);
               check("price", {32'd0, price}, {32'd0, e.pr});
            end
         end
      end
   end

   task automatic put_bytes(input logic [63:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) pkt.push_back(v[8*i +: 8]);
   endtask

   task automatic begin_pkt(input logic [63:0] seq, input logic [15:0] cnt);
      pkt.delete();
      pend_q.delete();
      pend_end.delete();
      for (int i = 0; i < 10; i++) pkt.push_back(8'($urandom));
      put_bytes(seq, 8);
      put_bytes({48'd0, cnt}, 2);
   endtask

   task automatic add_order(input rec_t r);
      logic [7:0] side;
      side = 8'($urandom);
      if (side == 8'h42) side = 8'h53;
      put_bytes(64'd36, 2);
      pkt.push_back(8'h41);
      put_bytes({48'd0, r.loc}, 2);
      put_bytes({32'd0, $urandom}, 2);
      put_bytes({16'd0, r.ts}, 6);
      put_bytes(r.ref_num, 8);
      pkt.push_back(r.buy ? 8'h42 : side);
      put_bytes({32'd0, r.sh}, 4);
      put_bytes(r.stk, 8);
      put_bytes({32'd0, r.pr}, 4);
      pend_q.push_back(r);
      pend_end.push_back(pkt.size() - 1);
   endtask

   task automatic add_other(input logic [7:0] typ, input int len);
      put_bytes(64'(len), 2);
      if (len > 0) pkt.push_back(typ);
      for (int i = 1; i < len; i++) pkt.push_back(8'($urandom));
   endtask

   function automatic rec_t rand_rec(input logic [63:0] s);
      rec_t r;
      r.seq     = s;
      r.loc     = 16'($urandom);
      r.ts      = 48'({$urandom, $urandom});
      r.ref_num = {$urandom, $urandom};
      r.buy     = 1'($urandom_range(0, 1));
      r.sh      = $urandom;
      r.stk     = {$urandom, $urandom};
      r.pr      = $urandom;
      return r;
   endfunction

   task automatic send_byte(input logic [7:0] b);
      dataValid = 1'b1;
      data      = b;
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      dataValid = 1'b0;
      data      = 8'h00;
      repeat (n) begin @(posedge clk); #1; end
   endtask

   // model: an order is expected only if its last byte is delivered; cutting before core end is an error
   task automatic send_pkt(input int cut);
      for (int i = 0; i < pend_q.size(); i++)
         if (pend_end[i] < cut) exp_q.push_back(pend_q[i]);
      if (cut < pkt_core) exp_err++;
      for (int i = 0; i < cut; i++) send_byte(pkt[i]);
      dataValid = 1'b0;
      data      = 8'h00;
   endtask

   initial begin
      rec_t r;
      logic [63:0] seq;
      logic [15:0] cnt;
      int cut;

      rstN = 1'b0; dataValid = 1'b0; data = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      check("rst_order_valid", {63'd0, orderValid}, 64'd0);
      check("rst_pkt_err", {63'd0, pktErr}, 64'd0);
      check("rst_seq_gap", {63'd0, seqGap}, 64'd0);
      check("rst_seq_num", seqNum, 64'd0);
      check("rst_price", {32'd0, price}, 64'd0);
      rstN = 1'b1;
      idle(2);

      // known add order, single message
      begin_pkt(64'h64, 16'd1);
      r = '{seq: 64'h64, loc: 16'h0001, ts: 48'h0000_1234_5678, ref_num: 64'h1122334455667788,
            buy: 1'b1, sh: 32'd100, stk: 64'h4141504C20202020, pr: 32'h0016E360};
      add_order(r);
      pkt_core = pkt.size();
      send_pkt(pkt.size());
      check("latency", {63'd0, orderValid}, 64'd1);
      idle(1);
      check("pulse_width", {63'd0, orderValid}, 64'd0);
      idle(1);

      // 'S' then sell add then buy add
      seq = 64'h0000_0000_0000_1000;
      begin_pkt(seq, 16'd3);
      add_other(8'h53, 12);
      r = rand_rec(seq + 64'd1); r.buy = 1'b0; add_order(r);
      r = rand_rec(seq + 64'd2); r.buy = 1'b1; add_order(r);
      pkt_core = pkt.size();
      send_pkt(pkt.size());
      idle(1);

      // heartbeat with trailing junk, then 'A' of length 35
      begin_pkt(64'd5, 16'd0);
      pkt_core = pkt.size();
      put_bytes(64'hDEAD_BEEF, 4);
      send_pkt(pkt.size());
      idle(1);
      begin_pkt(64'd7, 16'd1);
      add_other(8'h41, 35);
      pkt_core = pkt.size();
      send_pkt(pkt.size());
      idle(1);

      // truncated after body byte 20, then a good packet
      begin_pkt(64'd20, 16'd1);
      add_order(rand_rec(64'd20));
      pkt_core = pkt.size();
      send_pkt(20 + 2 + 21);
      idle(1);
      begin_pkt(64'd21, 16'd1);
      add_order(rand_rec(64'd21));
      pkt_core = pkt.size();
      send_pkt(pkt.size());
      idle(1);

      // sequence wrap
      seq = 64'hFFFF_FFFF_FFFF_FFFF;
      begin_pkt(seq, 16'd2);
      add_order(rand_rec(seq));
      add_order(rand_rec(seq + 64'd1));
      pkt_core = pkt.size();
      send_pkt(pkt.size());
      idle(1);

      // randomized packets
      for (int p = 0; p < 40; p++) begin
         int kind;
         seq  = {$urandom, $urandom};
         kind = $urandom_range(0, 9);
         if (kind == 0) cnt = 16'd0;
         else if (kind == 1) cnt = 16'hFFFF;
         else cnt = 16'($urandom_range(1, 4));
         begin_pkt(seq, cnt);
         if (cnt != 16'd0 && cnt != 16'hFFFF) begin
            for (int k = 0; k < int'(cnt); k++) begin
               case ($urandom_range(0, 3))
                  0, 1:    add_order(rand_rec(seq + 64'(k)));
                  2:       add_other(8'($urandom), $urandom_range(0, 20));
                  default: add_other(8'h41, ($urandom_range(0, 1) != 0) ? 35 : 37);
               endcase
            end
         end
         pkt_core = pkt.size();
         if ($urandom_range(0, 4) == 0) begin
            cut = $urandom_range(1, pkt_core - 1);
         end else begin
            if ($urandom_range(0, 3) == 0) put_bytes({$urandom, $urandom}, $urandom_range(1, 8));
            cut = pkt.size();
         end
         send_pkt(cut);
         idle($urandom_range(1, 3));
      end

      // async reset in the middle of an add-order body
      begin_pkt(64'd99, 16'd1);
      add_order(rand_rec(64'd99));
      for (int i = 0; i < 30; i++) send_byte(pkt[i]);
      rstN = 1'b0; dataValid = 1'b0; data = 8'h00;
      #1;
      check("rstmid_order_valid", {63'd0, orderValid}, 64'd0);
      check("rstmid_seq_num", seqNum, 64'd0);
      check("rstmid_ref_num", refNum, 64'd0);
      check("rstmid_stock", stock, 64'd0);
      check("rstmid_shares", {32'd0, shares}, 64'd0);
      check("rstmid_pkt_err", {63'd0, pktErr}, 64'd0);
      @(posedge clk); #1;
      rstN = 1'b1;
      idle(2);
      begin_pkt(64'd500, 16'd2);
      add_order(rand_rec(64'd500));
      add_order(rand_rec(64'd501));
      pkt_core = pkt.size();
      send_pkt(pkt.size());
      idle(4);

      check("orders_pending", 64'(exp_q.size()), 64'd0);
      check("pkt_err_count", 64'(err_cnt), 64'(exp_err));
      check("seq_gap_count", 64'(gap_cnt), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
